// File: rtl/axi_stream_pkg.sv
// Shared types and helpers for the AXI Stream header insert/strip blocks.
package axi_stream_pkg;

    typedef enum logic [1:0] {StIdle, StFirst, StStream, StFlush} strip_state_e;

    localparam int unsigned ByteWd   = 8;
    localparam int unsigned MaxBytes = 64;

    // Length of the run of set bits starting at bit nbytes-1 and walking down.
    function automatic int unsigned keep_count(input logic [MaxBytes-1:0] keep,
                                               input int unsigned nbytes);
        logic [MaxBytes-1:0] k;
        logic                run;
        int unsigned         cnt;
        k   = keep << (MaxBytes - nbytes);
        run = 1'b1;
        cnt = 0;
        for (int unsigned i = 0; i < MaxBytes; i++) begin
            run = run && k[MaxBytes-1] && (i < nbytes);
            if (run) cnt++;
            k = k << 1;
        end
        return cnt;
    endfunction

    // cnt MSB-contiguous ones within the low nbytes bits.
    function automatic logic [MaxBytes-1:0] keep_from_count(input int unsigned cnt,
                                                            input int unsigned nbytes);
        logic [MaxBytes-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < MaxBytes; i++) begin
            if (i < cnt) k = {1'b1, k[MaxBytes-1:1]};
        end
        return k >> (MaxBytes - nbytes);
    endfunction

endpackage

// File: rtl/axi_stream_strip_header_if.sv
// Stream in/out and strip-count side channel of the header-strip block.
interface axi_stream_strip_header_if #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;
    logic                    valid_strip;
    logic [BYTE_CNT_WD-1:0]  byte_strip_cnt;
    logic                    ready_strip;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out, valid_strip, byte_strip_cnt,
        output ready_in, valid_out, data_out, keep_out, last_out, ready_strip
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out, valid_strip, byte_strip_cnt,
        input  ready_in, valid_out, data_out, keep_out, last_out, ready_strip
    );
endinterface

// File: rtl/axi_stream_out_reg.sv
// Single registered output slice; holds its beat while the consumer stalls.
module axi_stream_out_reg #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    input  logic [DATA_WD-1:0]      data_i,
    input  logic [DATA_BYTE_WD-1:0] keep_i,
    input  logic                    last_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [DATA_WD-1:0]      data_o,
    output logic [DATA_BYTE_WD-1:0] keep_o,
    output logic                    last_o,
    input  logic                    ready_i
);
    logic                    valid_q, valid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                    last_q, last_d;

    assign ready_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
                keep_d = keep_i;
                last_d = last_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;
endmodule

// File: rtl/axi_stream_strip_header.sv
// Removes a per-packet count of leading bytes from an AXI Stream packet and repacks
// the remaining payload into MSB-aligned beats.
module axi_stream_strip_header
    import axi_stream_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input logic                      clk,
    input logic                      rst_n,
    axi_stream_strip_header_if.slave bus
);
    localparam logic [BYTE_CNT_WD:0] ShiftFull = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

    strip_state_e            state_q, state_d;
    logic [BYTE_CNT_WD-1:0]  strip_q, strip_d;
    logic [DATA_WD-1:0]      residue_q, residue_d;
    logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;

    logic [BYTE_CNT_WD:0]    shift;
    int unsigned             last_len;
    logic [DATA_WD-1:0]      head_src, head_data, stream_data;
    logic [DATA_BYTE_WD-1:0] head_ksrc, head_keep, stream_keep;
    logic                    out_free, in_fire;
    logic                    emit_valid, emit_last;
    logic [DATA_WD-1:0]      emit_data, emit_data_masked;
    logic [DATA_BYTE_WD-1:0] emit_keep;

    assign bus.ready_strip = (state_q == StIdle);
    assign bus.ready_in    = ((state_q == StFirst) || (state_q == StStream)) && out_free;
    assign in_fire         = bus.valid_in && bus.ready_in;

    // S=0 shifts by a whole beat so the stream window degenerates to data_in.
    always_comb begin
        shift       = (strip_q == '0) ? ShiftFull : {1'b0, strip_q};
        last_len    = keep_count(MaxBytes'(bus.keep_in), DATA_BYTE_WD);
        head_src    = (state_q == StFlush) ? residue_q  : bus.data_in;
        head_ksrc   = (state_q == StFlush) ? res_keep_q : bus.keep_in;
        stream_data = DATA_WD'(({residue_q, bus.data_in} << (ByteWd * 32'(shift))) >> DATA_WD);
        stream_keep = DATA_BYTE_WD'(({res_keep_q, bus.keep_in} << shift) >> DATA_BYTE_WD);
        head_data   = DATA_WD'(({head_src, {DATA_WD{1'b0}}} << (ByteWd * 32'(strip_q)))
                               >> DATA_WD);
        head_keep   = DATA_BYTE_WD'(({head_ksrc, {DATA_BYTE_WD{1'b0}}} << strip_q)
                                    >> DATA_BYTE_WD);
    end

    always_comb begin
        state_d    = state_q;
        strip_d    = strip_q;
        residue_d  = residue_q;
        res_keep_d = res_keep_q;
        emit_valid = 1'b0;
        emit_last  = 1'b0;
        emit_data  = head_data;
        emit_keep  = head_keep;
        unique case (state_q)
            StIdle: begin
                if (bus.valid_strip) begin
                    strip_d = bus.byte_strip_cnt;
                    state_d = StFirst;
                end
            end
            StFirst: begin
                if (in_fire) begin
                    residue_d  = bus.data_in;
                    res_keep_d = bus.keep_in;
                    if (!bus.last_in) begin
                        emit_valid = (strip_q == '0);
                        state_d    = StStream;
                    end else begin
                        emit_valid = (last_len > 32'(strip_q));
                        emit_last  = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StStream: begin
                if (in_fire) begin
                    residue_d  = bus.data_in;
                    res_keep_d = bus.keep_in;
                    emit_valid = 1'b1;
                    emit_data  = stream_data;
                    emit_keep  = stream_keep;
                    if (bus.last_in) begin
                        if (last_len <= 32'(shift)) begin
                            emit_last = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                if (out_free) begin
                    emit_valid = 1'b1;
                    emit_last  = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Lanes without keep are forced to zero so input junk never leaks out.
    always_comb begin
        emit_data_masked = '0;
        for (int unsigned b = 0; b < DATA_BYTE_WD; b++) begin
            emit_data_masked[b*ByteWd +: ByteWd] = emit_data[b*ByteWd +: ByteWd]
                                                   & {ByteWd{emit_keep[b]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            strip_q    <= '0;
            residue_q  <= '0;
            res_keep_q <= '0;
        end else begin
            state_q    <= state_d;
            strip_q    <= strip_d;
            residue_q  <= residue_d;
            res_keep_q <= res_keep_d;
        end
    end

    axi_stream_out_reg #(
        .DATA_WD     (DATA_WD),
        .DATA_BYTE_WD(DATA_BYTE_WD)
    ) u_out_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(emit_valid),
        .data_i (emit_data_masked),
        .keep_i (emit_keep),
        .last_i (emit_last),
        .ready_o(out_free),
        .valid_o(bus.valid_out),
        .data_o (bus.data_out),
        .keep_o (bus.keep_out),
        .last_o (bus.last_out),
        .ready_i(bus.ready_out)
    );
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: vector table, corner sequences, random packets vs model.
module tb_axi_stream_strip_header;
    import axi_stream_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        int                   s;
        int                   nb;
        logic [2:0][DW-1:0]   d;
        logic [2:0][BW-1:0]   k;
        int                   ne;
        logic [2:0][DW-1:0]   ed;
        logic [2:0][BW-1:0]   ek;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  bp_en = 1'b0;
    int    tests = 0;
    int    fails = 0;
    beat_t got[$];
    logic  stalled_prev = 1'b0;
    beat_t hold;
    vec_t  vecs[5];

    axi_stream_strip_header_if #(.DATA_WD(DW)) bus ();

    axi_stream_strip_header #(.DATA_WD(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        bus.ready_out = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: records accepted beats and checks stability under backpressure.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.valid_out === 1'b1) begin
            if (stalled_prev) begin
                check("stall_data", bus.data_out, hold.data);
                check("stall_keep", DW'(bus.keep_out), DW'(hold.keep));
                check("stall_last", DW'(bus.last_out), DW'(hold.last));
            end
            hold.data    = bus.data_out;
            hold.keep    = bus.keep_out;
            hold.last    = bus.last_out;
            stalled_prev = !bus.ready_out;
            if (bus.ready_out) got.push_back(hold);
        end else begin
            if (stalled_prev && rst_n === 1'b1) check("stall_valid", DW'(bus.valid_out), 1);
            stalled_prev = 1'b0;
        end
    end

    // Expected output from the payload-bytes view: drop S bytes, chunk, MSB-align.
    function automatic void model(input int s, input logic [7:0] pkt[$], output beat_t exp[$]);
        int                  idx;
        int                  n;
        beat_t               b;
        logic [MaxBytes-1:0] kk;
        exp = {};
        idx = s;
        while (idx < pkt.size()) begin
            n = (pkt.size() - idx > BW) ? BW : pkt.size() - idx;
            b = '0;
            for (int j = 0; j < n; j++) b.data[DW-1-8*j -: 8] = pkt[idx+j];
            kk     = keep_from_count(n, BW);
            b.keep = kk[BW-1:0];
            idx   += n;
            b.last = (idx == pkt.size());
            exp.push_back(b);
        end
    endfunction

    task automatic send_strip(input int s);
        logic hs;
        int   g;
        hs = 1'b0;
        g  = 0;
        bus.valid_strip    = 1'b1;
        bus.byte_strip_cnt = 2'(s);
        while (!hs && g < 200) begin
            @(negedge clk);
            hs = bus.ready_strip;
            @(posedge clk);
            #1;
            g++;
        end
        bus.valid_strip = 1'b0;
        if (!hs) check("strip_handshake", DW'(hs), 1);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l,
                             output int waits);
        logic hs;
        int   g;
        hs = 1'b0;
        g  = 0;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        while (!hs && g < 200) begin
            @(negedge clk);
            hs = bus.ready_in;
            @(posedge clk);
            #1;
            g++;
        end
        bus.valid_in = 1'b0;
        waits = g - 1;
        if (!hs) check("beat_handshake", DW'(hs), 1);
    endtask

    task automatic wait_out(input int n);
        int g;
        g = 0;
        while (got.size() < n && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic compare_out(input string tag, input beat_t exp[$]);
        check({tag, "_count"}, DW'(got.size()), DW'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_b%0d_data", tag, i), got[i].data, exp[i].data);
            check($sformatf("%s_b%0d_keep", tag, i), DW'(got[i].keep), DW'(exp[i].keep));
            check($sformatf("%s_b%0d_last", tag, i), DW'(got[i].last), DW'(exp[i].last));
        end
        got.delete();
    endtask

    task automatic run_pkt(input string tag, input int s, input logic [7:0] pkt[$]);
        beat_t               exp[$];
        int                  idx;
        int                  n;
        int                  w;
        logic [DW-1:0]       d;
        logic [MaxBytes-1:0] kk;
        model(s, pkt, exp);
        send_strip(s);
        idx = 0;
        while (idx < pkt.size()) begin
            n = (pkt.size() - idx > BW) ? BW : pkt.size() - idx;
            d = $urandom;  // lanes beyond the packet carry junk
            for (int j = 0; j < n; j++) d[DW-1-8*j -: 8] = pkt[idx+j];
            kk   = keep_from_count(n, BW);
            idx += n;
            send_beat(d, kk[BW-1:0], idx == pkt.size(), w);
        end
        wait_out(exp.size());
        compare_out(tag, exp);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        beat_t exp[$];
        beat_t b;
        int    w;
        int    stalls;
        send_strip(v.s);
        stalls = 0;
        for (int i = 0; i < v.nb; i++) begin
            send_beat(v.d[i], v.k[i], i == v.nb - 1, w);
            stalls += w;
            if (v.s == 0 && !bp_en) begin
                check({tag, "_lat_valid"}, DW'(bus.valid_out), 1);
                check({tag, "_lat_data"}, bus.data_out, v.d[i]);
            end
        end
        if (v.s == 0 && !bp_en) check({tag, "_in_stalls"}, DW'(stalls), 0);
        if (v.ne == 0) begin
            @(negedge clk);
            check({tag, "_ready_strip"}, DW'(bus.ready_strip), 1);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < v.ne; i++) begin
            b.data = v.ed[i];
            b.keep = v.ek[i];
            b.last = (i == v.ne - 1);
            exp.push_back(b);
        end
        wait_out(v.ne);
        compare_out(tag, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            w;
        logic [7:0]    pkt[$];
        bus.valid_in       = 1'b0;
        bus.data_in        = '0;
        bus.keep_in        = '0;
        bus.last_in        = 1'b0;
        bus.valid_strip    = 1'b0;
        bus.byte_strip_cnt = '0;
        rst_n              = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", DW'(bus.valid_out), 0);
        check("rst_last_out", DW'(bus.last_out), 0);
        check("rst_keep_out", DW'(bus.keep_out), 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_ready_strip", DW'(bus.ready_strip), 1);
        check("rst_ready_in", DW'(bus.ready_in), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) vecs[i] = '0;
        vecs[0].s = 1; vecs[0].nb = 2;
        vecs[0].d[0] = 32'hAABBCCDD; vecs[0].k[0] = 4'hF;
        vecs[0].d[1] = 32'h11223344; vecs[0].k[1] = 4'hF;
        vecs[0].ne = 2;
        vecs[0].ed[0] = 32'hBBCCDD11; vecs[0].ek[0] = 4'hF;
        vecs[0].ed[1] = 32'h22334400; vecs[0].ek[1] = 4'hE;
        vecs[1].s = 2; vecs[1].nb = 2;
        vecs[1].d[0] = 32'hAABBCCDD; vecs[1].k[0] = 4'hF;
        vecs[1].d[1] = 32'h11000000; vecs[1].k[1] = 4'h8;
        vecs[1].ne = 1;
        vecs[1].ed[0] = 32'hCCDD1100; vecs[1].ek[0] = 4'hE;
        vecs[2].s = 0; vecs[2].nb = 3;
        vecs[2].d[0] = 32'h01020304; vecs[2].k[0] = 4'hF;
        vecs[2].d[1] = 32'h05060708; vecs[2].k[1] = 4'hF;
        vecs[2].d[2] = 32'h090A0B0C; vecs[2].k[2] = 4'hF;
        vecs[2].ne = 3;
        vecs[2].ed[0] = 32'h01020304; vecs[2].ek[0] = 4'hF;
        vecs[2].ed[1] = 32'h05060708; vecs[2].ek[1] = 4'hF;
        vecs[2].ed[2] = 32'h090A0B0C; vecs[2].ek[2] = 4'hF;
        vecs[3].s = 3; vecs[3].nb = 1;
        vecs[3].d[0] = 32'hAABBCC00; vecs[3].k[0] = 4'hE;
        vecs[3].ne = 0;
        vecs[4].s = 1; vecs[4].nb = 1;
        vecs[4].d[0] = 32'hAABBCCDD; vecs[4].k[0] = 4'hF;
        vecs[4].ne = 1;
        vecs[4].ed[0] = 32'hBBCCDD00; vecs[4].ek[0] = 4'hE;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        bp_en = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(vecs[0], $sformatf("bp_s1_%0d", i));
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while in the middle of a packet, then a clean S=2 packet.
        send_strip(2);
        send_beat(32'h01020304, 4'hF, 1'b0, w);
        send_beat(32'h05060708, 4'hF, 1'b0, w);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid_out", DW'(bus.valid_out), 0);
        check("midrst_ready_strip", DW'(bus.ready_strip), 1);
        check("midrst_ready_in", DW'(bus.ready_in), 0);
        rst_n = 1'b1;
        got.delete();
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        run_pkt("post_rst", 2, pkt);

        bp_en = 1'b1;
        for (int p = 0; p < 150; p++) begin
            int len;
            len = $urandom_range(1, 14);
            pkt = {};
            for (int j = 0; j < len; j++) pkt.push_back(8'($urandom));
            run_pkt($sformatf("rnd%0d", p), $urandom_range(0, BW - 1), pkt);
        end
        bp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
